// File: rtl/score_pkg.sv
// score_pkg: shared constants, types and helpers for the score keeper.
//   - Default point values per enemy kind.
//   - BCD_MAX: the largest displayable score, 9999, in BCD.
//   - bcd_digit_t: one BCD digit.
//   - popcount(): number of set bits in a kill-pulse vector.
package score_pkg;

  localparam int FLY_POINTS_DEF      = 10;
  localparam int MOSQUITO_POINTS_DEF = 20;
  localparam int SPIDER_POINTS_DEF   = 500;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  typedef logic [3:0] bcd_digit_t;

  // Counts set bits. Callers zero-extend their vector to 32 bits.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd4_incr.sv
// bcd4_incr: combinational +1 on a 4-digit packed BCD value.
//   value     in  16  BCD input, [15:12] is the thousands digit
//   result    out 16  value + 1 in BCD (wraps 9999 -> 0000)
//   carry_out out 1   high when value is 9999, i.e. the increment overflows
module bcd4_incr
  import score_pkg::*;
(
  input  logic [15:0] value,
  output logic [15:0] result,
  output logic        carry_out
);

  logic       carry;
  bcd_digit_t digit;

  // NOTE: combinational logic uses blocking assignments and gives every
  // output a default first, so no path leaves a value held (no latch).
  always_comb begin
    carry  = 1'b1;
    result = '0;
    digit  = '0;
    for (int i = 0; i < 4; i++) begin
      digit = value[i*4 +: 4];
      if (carry) begin
        if (digit == 4'd9) begin
          digit = 4'd0;
        end else begin
          digit = digit + 4'd1;
          carry = 1'b0;
        end
      end
      result[i*4 +: 4] = digit;
    end
    carry_out = carry;
  end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: turns per-cycle kill pulses into a rolling 4-digit BCD score,
// keeps the best committed score, and requests a retriggerable hit sound.
// Points are queued in a pending accumulator and drained one per clock.
//   clk25        in  1               pixel clock, all state on rising edge
//   reset        in  1               synchronous active-high, clears everything
//   round_clear  in  1               commit high score, zero score and pending
//   fly_hit      in  FLY_COUNT       one-cycle kill pulse per fly slot
//   mosquito_hit in  MOSQUITO_COUNT  one-cycle kill pulse per mosquito slot
//   spider_hit   in  1               one-cycle boss-kill pulse
//   score_bcd    out 16              current score, BCD
//   hiscore_bcd  out 16              best committed score, BCD
//   busy         out 1               pending points nonzero
//   sfx_hit      out 1               hit-sound timer running
module score_keeper
  import score_pkg::*;
#(
  parameter int FLY_COUNT       = 4,
  parameter int MOSQUITO_COUNT  = 8,
  parameter int FLY_POINTS      = FLY_POINTS_DEF,
  parameter int MOSQUITO_POINTS = MOSQUITO_POINTS_DEF,
  parameter int SPIDER_POINTS   = SPIDER_POINTS_DEF,
  parameter int PENDING_W       = 12,
  parameter int SFX_LEN         = 2_500_000
) (
  input  logic                      clk25,
  input  logic                      reset,
  input  logic                      round_clear,
  input  logic [FLY_COUNT-1:0]      fly_hit,
  input  logic [MOSQUITO_COUNT-1:0] mosquito_hit,
  input  logic                      spider_hit,
  output logic [15:0]               score_bcd,
  output logic [15:0]               hiscore_bcd,
  output logic                      busy,
  output logic                      sfx_hit
);

  localparam int SFX_W = $clog2(SFX_LEN + 1);

  logic [PENDING_W-1:0] pending;
  logic [PENDING_W-1:0] sum;
  logic [PENDING_W:0]   pending_wide;
  logic [PENDING_W-1:0] pending_next;
  logic [15:0]          score_q;
  logic [15:0]          hiscore_q;
  logic [15:0]          score_inc;
  logic                 score_at_max;
  logic                 tick;
  logic [SFX_W-1:0]     sfx_cnt;

  // Increment overflow only happens from 9999, so the carry doubles as the
  // "score is at maximum" flag.
  bcd4_incr u_incr (
    .value     (score_q),
    .result    (score_inc),
    .carry_out (score_at_max)
  );

  assign sum = PENDING_W'(popcount(32'(fly_hit)) * FLY_POINTS)
             + PENDING_W'(popcount(32'(mosquito_hit)) * MOSQUITO_POINTS)
             + (spider_hit ? PENDING_W'(SPIDER_POINTS) : '0);

  assign tick = (pending != '0) && !score_at_max;

  // One extra bit catches overflow; tick is only set when pending is
  // nonzero, so the subtraction can never underflow.
  assign pending_wide = {1'b0, pending} + {1'b0, sum}
                      - {{PENDING_W{1'b0}}, tick};
  assign pending_next = pending_wide[PENDING_W] ? '1
                                                : pending_wide[PENDING_W-1:0];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk25) begin
    if (reset) begin
      pending   <= '0;
      score_q   <= '0;
      hiscore_q <= '0;
      sfx_cnt   <= '0;
    end else begin
      if (round_clear) begin
        // Packed BCD compares in the same order as the numbers it encodes.
        if (score_q > hiscore_q) hiscore_q <= score_q;
        score_q <= '0;
        pending <= '0;
      end else if (score_at_max) begin
        // Score is pinned at 9999: drop queued and arriving points.
        pending <= '0;
      end else begin
        pending <= pending_next;
        if (tick) score_q <= score_inc;
      end

      // Retrigger reloads rather than extends.
      if (!round_clear && (sum != '0)) begin
        sfx_cnt <= SFX_W'(SFX_LEN);
      end else if (sfx_cnt != '0) begin
        sfx_cnt <= sfx_cnt - SFX_W'(1);
      end
    end
  end

  assign score_bcd   = score_q;
  assign hiscore_bcd = hiscore_q;
  assign busy        = (pending != '0);
  assign sfx_hit     = (sfx_cnt != '0);

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: self-checking bench for score_keeper (SFX_LEN shortened
// to 8). Inputs change on the falling edge; outputs are sampled there too.
module tb_score_keeper;

  localparam int SFX_LEN = 8;

  logic        clk25 = 1'b0;
  logic        reset;
  logic        round_clear;
  logic [3:0]  fly_hit;
  logic [7:0]  mosquito_hit;
  logic        spider_hit;
  logic [15:0] score_bcd;
  logic [15:0] hiscore_bcd;
  logic        busy;
  logic        sfx_hit;

  always #5 clk25 = ~clk25;

  score_keeper #(.SFX_LEN(SFX_LEN)) dut (
    .clk25        (clk25),
    .reset        (reset),
    .round_clear  (round_clear),
    .fly_hit      (fly_hit),
    .mosquito_hit (mosquito_hit),
    .spider_hit   (spider_hit),
    .score_bcd    (score_bcd),
    .hiscore_bcd  (hiscore_bcd),
    .busy         (busy),
    .sfx_hit      (sfx_hit)
  );

  typedef struct {
    string      name;
    logic [3:0] fly;
    logic [7:0] mos;
    logic       spider;
    int         pts;
  } vec_t;

  vec_t        vecs[5];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          total;
  int          n;
  int          sfx_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(posedge clk25);
    @(negedge clk25);
  endtask

  task automatic pulse(input logic [3:0] f, input logic [7:0] m, input logic s);
    fly_hit      = f;
    mosquito_hit = m;
    spider_hit   = s;
    step();
    fly_hit      = '0;
    mosquito_hit = '0;
    spider_hit   = 1'b0;
  endtask

  task automatic clear_round();
    round_clear = 1'b1;
    step();
    round_clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Steps until busy drops; cnt is the number of edges that took.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 20000) begin
      step();
      cnt++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, cnt);
    end
  endtask

  // Scoreboard drain: expected final score was queued when stimulus went in.
  task automatic finish_roll(input string name);
    int c;
    wait_idle(c);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: score %0h but no expected value queued", name, score_bcd);
    end else begin
      check(name, score_bcd, exp_q.pop_front());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; round_clear = 1'b0;
    fly_hit = '0; mosquito_hit = '0; spider_hit = 1'b0;
    step(); step();
    reset = 1'b0;
    check("reset_score",   score_bcd,   16'h0000);
    check("reset_hiscore", hiscore_bcd, 16'h0000);
    check("reset_busy",    busy,        1'b0);
    check("reset_sfx",     sfx_hit,     1'b0);

    // Single fly: 10 points, one per edge, sound for SFX_LEN cycles.
    pulse(4'b0001, 8'h00, 1'b0);
    check("fly_busy",       busy,      1'b1);
    check("fly_sfx_rise",   sfx_hit,   1'b1);
    check("fly_score_at_e", score_bcd, 16'h0000);
    sfx_n = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (sfx_hit) sfx_n++;
      if (i == 1) check("fly_first_tick", score_bcd, 16'h0001);
      if (i == 9) check("fly_busy_e9", busy, 1'b1);
    end
    check("fly_score_e10", score_bcd, 16'h0010);
    check("fly_busy_e10",  busy,      1'b0);
    check("fly_sfx_len",   sfx_n,     SFX_LEN);
    check("fly_sfx_low",   sfx_hit,   1'b0);

    clear_round();
    check("rc1_hiscore", hiscore_bcd, 16'h0010);
    check("rc1_score",   score_bcd,   16'h0000);

    // Table-driven single-cycle events from score 0.
    vecs[0] = '{"all_enemies",  4'hF,       8'hFF, 1'b1, 700};
    vecs[1] = '{"two_flies",    4'b0110,    8'h00, 1'b0, 20};
    vecs[2] = '{"edge_mosq",    4'b0000,    8'h81, 1'b0, 40};
    vecs[3] = '{"spider_only",  4'b0000,    8'h00, 1'b1, 500};
    vecs[4] = '{"mixed",        4'b1010,    8'h0F, 1'b0, 100};
    total = 0;
    for (int i = 0; i < 5; i++) begin
      total += vecs[i].pts;
      exp_q.push_back(to_bcd(total));
      pulse(vecs[i].fly, vecs[i].mos, vecs[i].spider);
      check({vecs[i].name, "_busy"}, busy, 1'b1);
      wait_idle(n);
      check({vecs[i].name, "_cycles"}, n, vecs[i].pts);
      check({vecs[i].name, "_score"}, score_bcd, exp_q.pop_front());
    end

    // Event mid roll-up: pending 5 plus a mosquito nets to 24.
    clear_round();
    check("rc2_hiscore", hiscore_bcd, 16'h1360);
    pulse(4'b0001, 8'h00, 1'b0);
    repeat (5) step();
    check("mid_score_5", score_bcd, 16'h0005);
    pulse(4'b0000, 8'h01, 1'b0);
    check("mid_score_6", score_bcd, 16'h0006);
    wait_idle(n);
    check("mid_pending_24", n, 24);
    check("mid_final", score_bcd, 16'h0030);

    // Back-to-back events all accumulate.
    clear_round();
    exp_q.push_back(16'h0030);
    pulse(4'b0001, 8'h00, 1'b0);
    pulse(4'b0010, 8'h00, 1'b0);
    pulse(4'b0100, 8'h00, 1'b0);
    finish_roll("b2b_final");

    // High-score commit ordering.
    do_reset();
    check("rst2_hiscore", hiscore_bcd, 16'h0000);
    exp_q.push_back(16'h0300);
    pulse(4'hF, 8'hFF, 1'b0);
    pulse(4'h0, 8'h1F, 1'b0);
    finish_roll("hs_300");
    clear_round();
    check("hs_commit_300", hiscore_bcd, 16'h0300);
    exp_q.push_back(16'h0450);
    pulse(4'hF, 8'hFF, 1'b0);
    pulse(4'hF, 8'hFF, 1'b0);
    pulse(4'b0001, 8'h03, 1'b0);
    finish_roll("hs_450");
    check("hs_not_live", hiscore_bcd, 16'h0300);
    clear_round();
    check("hs_commit_450", hiscore_bcd, 16'h0450);
    check("hs_score_zero", score_bcd,   16'h0000);
    check("hs_busy_zero",  busy,        1'b0);
    exp_q.push_back(16'h0200);
    pulse(4'hF, 8'hFF, 1'b0);
    finish_roll("hs_200");
    clear_round();
    check("hs_keep_450", hiscore_bcd, 16'h0450);

    // round_clear with a kill in the same cycle: kill ignored.
    repeat (SFX_LEN + 2) step();
    check("rcfly_pre_sfx", sfx_hit, 1'b0);
    round_clear = 1'b1;
    fly_hit     = 4'b0001;
    step();
    round_clear = 1'b0;
    fly_hit     = '0;
    check("rcfly_score", score_bcd, 16'h0000);
    check("rcfly_busy",  busy,      1'b0);
    check("rcfly_sfx",   sfx_hit,   1'b0);

    // Pending saturates at 4095: six 700s back-to-back give 4100, not 4200.
    exp_q.push_back(16'h4100);
    repeat (6) pulse(4'hF, 8'hFF, 1'b1);
    finish_roll("sat_pending");

    // Climb to 9990 without saturating pending.
    exp_q.push_back(16'h7600);
    repeat (5) pulse(4'hF, 8'hFF, 1'b1);
    finish_roll("climb_7600");
    exp_q.push_back(16'h9700);
    repeat (3) pulse(4'hF, 8'hFF, 1'b1);
    finish_roll("climb_9700");
    exp_q.push_back(16'h9990);
    pulse(4'hF, 8'hFF, 1'b0);
    pulse(4'b0001, 8'h0F, 1'b0);
    finish_roll("climb_9990");

    // Spider at 9990: score stops at 9999, pending flushed next edge.
    pulse(4'h0, 8'h00, 1'b1);
    check("max_busy_e", busy, 1'b1);
    repeat (9) step();
    check("max_score_e9", score_bcd, 16'h9999);
    check("max_busy_e9",  busy,      1'b1);
    step();
    check("max_busy_e10",  busy,      1'b0);
    check("max_score_e10", score_bcd, 16'h9999);
    pulse(4'b0001, 8'h00, 1'b0);
    check("max_discard_busy",  busy,      1'b0);
    check("max_discard_score", score_bcd, 16'h9999);
    check("max_discard_sfx",   sfx_hit,   1'b1);
    clear_round();
    check("max_commit", hiscore_bcd, 16'h9999);

    // Reset in the middle of a roll-up forgets everything.
    pulse(4'h0, 8'h00, 1'b1);
    repeat (5) step();
    check("rstmid_busy_pre", busy, 1'b1);
    do_reset();
    check("rstmid_score",   score_bcd,   16'h0000);
    check("rstmid_hiscore", hiscore_bcd, 16'h0000);
    check("rstmid_busy",    busy,        1'b0);
    check("rstmid_sfx",     sfx_hit,     1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
